// File: rtl/cpu_pkg.sv
// Shared definitions for the hazard controller: FSM encodings, MDU latencies
// and the hard-wired zero register number.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MDBUSY = 2'd1,
    EXC    = 2'd2
  } hz_state_e;

  localparam int CNT_W   = 4;
  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The counter runs down to zero inclusive, so it is loaded with latency-1.
  function automatic logic [CNT_W-1:0] md_load_val(input logic is_div);
    return is_div ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Multiply/divide latency timer: down-counter plus busy/done flags,
// loaded when an operation starts and cleared when it is aborted.
module md_timer
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic load,
  input  logic load_div,
  input  logic abort,
  input  logic busy,
  output logic md_busy,
  output logic md_done,
  output logic cnt_last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = md_load_val(load_div);
    end else if (busy && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_last = busy && (cnt_q == '0);
  assign md_busy  = busy;
  // An aborted operation never reports completion, even on its last cycle.
  assign md_done  = cnt_last && !abort;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and MDU-busy stalls, exception flush,
// and the RUN/MDBUSY/EXC sequencing that tracks the multiply/divide unit.
module hazard_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_md,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       md_start,
  input  logic       md_div,
  input  logic       exc_req,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic       flush_all,
  output logic       md_busy,
  output logic       md_done
);

  hz_state_e state_q, state_d;
  logic      cnt_last;
  logic      md_load;
  logic      load_use;
  logic      md_hazard;
  logic      stall_ok;
  logic      stall;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (exc_req)       state_d = EXC;
        else if (md_start) state_d = MDBUSY;
      end
      MDBUSY: begin
        if (exc_req)       state_d = EXC;
        else if (cnt_last) state_d = RUN;
      end
      EXC: begin
        state_d = exc_req ? EXC : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A start only takes effect from RUN and loses to a same-cycle exception.
  assign md_load = (state_q == RUN) && md_start && !exc_req;

  md_timer u_md_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (md_load),
    .load_div (md_div),
    .abort    (exc_req),
    .busy     (state_q == MDBUSY),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .cnt_last (cnt_last)
  );

  assign load_use = ex_is_load && (ex_rd != REG_ZERO) &&
                    ((id_use_rs && (ex_rd == id_rs)) ||
                     (id_use_rt && (ex_rd == id_rt)));

  assign md_hazard = id_is_md && (md_busy || md_start);

  // Reset and exception flushing override every stall request.
  assign stall_ok  = clr_n && !exc_req && (state_q != EXC);
  assign stall     = stall_ok && (load_use || md_hazard);

  assign stall_f   = stall;
  assign stall_d   = stall;
  assign flush_e   = stall;
  assign flush_all = !clr_n || exc_req || (state_q == EXC);

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-002 SHALL have port clr_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have ports id_rs and id_rt, inputs, 5 bits each: source register numbers of the instruction in the ID stage.
REQ-004 SHALL have ports id_use_rs and id_use_rt, inputs, 1 bit each: the ID instruction reads that source register.
REQ-005 SHALL have port id_is_md, input, 1 bit: the ID instruction is mult, div, mfhi, mflo, mthi or mtlo.
REQ-006 SHALL have port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-007 SHALL have port ex_is_load, input, 1 bit: the EX instruction is a load.
REQ-008 SHALL have port md_start, input, 1 bit: the EX instruction starts a multiply or divide.
REQ-009 SHALL have port md_div, input, 1 bit: when set, the started operation is a divide; when clear, it is a multiply.
REQ-010 SHALL have port exc_req, input, 1 bit: an exception or eret is committed in MEM.
REQ-011 SHALL have port stall_f, output, 1 bit: hold the PC.
REQ-012 SHALL have port stall_d, output, 1 bit: drives the stall input of the IF/ID pipeline_reg.
REQ-013 SHALL have port flush_e, output, 1 bit: drives the flush input of the ID/EX pipeline_reg, inserting a bubble.
REQ-014 SHALL have port flush_all, output, 1 bit: drives flush on the IF/ID, ID/EX and EX/MEM registers.
REQ-015 SHALL have port md_busy, output, 1 bit: the MDU is counting.
REQ-016 SHALL have port md_done, output, 1 bit: a one-cycle pulse on the last busy cycle.

Function
REQ-017 SHALL implement FSM states RUN, MDBUSY and EXC, plus a 4-bit down-counter cnt.
REQ-018 In RUN, md_start=1 with exc_req=0 SHALL move to MDBUSY at the next edge, loading cnt=4 when md_div=0 or cnt=9 when md_div=1; this gives 5 or 10 busy cycles.
REQ-019 In MDBUSY, cnt SHALL decrement each cycle; at cnt=0, md_done=1 for that cycle and the FSM SHALL return to RUN at the next edge.
REQ-020 md_busy SHALL be 1 exactly while the state is MDBUSY.
REQ-021 A load-use hazard SHALL be detected combinationally when ex_is_load=1, ex_rd!=0, and ex_rd matches id_rs (with id_use_rs=1) or id_rt (with id_use_rt=1).
REQ-022 An MDU hazard SHALL be detected when id_is_md=1 and either md_busy=1 or md_start=1.
REQ-023 Whenever either hazard is detected, stall_f=stall_d=flush_e=1 in the same cycle.
REQ-024 exc_req=1 SHALL force flush_all=1 combinationally in the same cycle and SHALL force stall_f=stall_d=flush_e=0, taking priority over all hazards.
REQ-025 exc_req=1 in any state SHALL move to EXC at the next edge, clear cnt and abort any MDU operation; md_done SHALL NOT pulse.
REQ-026 EXC SHALL last exactly one cycle with flush_all=1 and all stalls at 0, then return to RUN, unless exc_req is still 1, in which case it SHALL stay in EXC.
REQ-027 md_start arriving in MDBUSY SHALL be ignored, because the MDU hazard stall prevents a legal occurrence.
REQ-028 md_start and exc_req in the same cycle SHALL be resolved with exc_req winning, so no MDU operation starts.
REQ-029 With no hazard and no exception, all stall and flush outputs SHALL be 0.

Reset
REQ-030 clr_n=0 SHALL asynchronously force state=RUN and cnt=0.
REQ-031 During reset the outputs SHALL be stall_f=stall_d=flush_e=0, flush_all=1, md_busy=0 and md_done=0, so the pipeline registers clear while reset is held.
REQ-032 Reset asserted during MDBUSY or EXC SHALL abandon the operation, with no md_done pulse after release.
REQ-033 The first edge after clr_n rises SHALL be evaluated from RUN.

Structure
REQ-034 FSM state encodings, the MDU latency constants (MUL_CYC=5, DIV_CYC=10) and the register-zero constant SHALL live in the shared package cpu_pkg.
REQ-035 The block SHALL contain one natural sub-module, md_timer, which holds the counter, the md_busy/md_done logic and its load/abort inputs; the hazard logic SHALL stay at top level.

Verification
REQ-036 Load-use: ex_is_load=1, ex_rd=8, id_rs=8, id_use_rs=1 -> stall_f=stall_d=flush_e=1 for that cycle; with ex_rd=0 -> all outputs 0.
REQ-037 Divide: md_start=1 with md_div=1, then id_is_md=1 held -> md_busy=1 for 10 cycles, md_done on the 10th, and stalls deassert on the cycle after md_done.
REQ-038 Exception mid-multiply: exc_req=1 on the 3rd busy cycle -> flush_all=1 that cycle and the next, md_busy=0 after the edge, and md_done never pulses.
REQ-039 Simultaneous events: md_start=1, exc_req=1 and a load-use condition in one cycle -> flush_all=1, stalls=0, and no MDBUSY entered.
REQ-040 Reset mid-divide: clr_n=0 on the 4th busy cycle -> md_busy=0 immediately and flush_all=1; after release, id_is_md=1 with no md_start -> no stall.
